// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
package instr_queue_pkg;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  localparam logic [XLEN-1:0] BUBBLE = '0;

  typedef enum logic [1:0] {
    Q_RUN,
    Q_DRAIN,
    Q_DONE
  } iq_state_t;

endpackage

// File: rtl/instr_queue_mem.sv
// Circular DEPTH x XLEN storage: two ordered write ports at (wptr, wptr+1),
// two asynchronous read ports at (rptr, rptr+1).
module instr_queue_mem
  import instr_queue_pkg::*;
#(
  parameter int XLEN  = instr_queue_pkg::XLEN,
  parameter int DEPTH = instr_queue_pkg::DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic [PW-1:0]   wptr,
  input  logic            wa_en,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  logic [XLEN-1:0] wb_data,
  input  logic [PW-1:0]   rptr,
  output logic [XLEN-1:0] rd0,
  output logic [XLEN-1:0] rd1
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr_b;
  logic [PW-1:0]   rptr_b;

  assign wptr_b = wptr + PW'(1);
  assign rptr_b = rptr + PW'(1);

  // NOTE: storage has no reset; occupancy is tracked by count, so stale data is never presented.
  always_ff @(posedge clk) begin
    if (wa_en) mem[wptr]   <= wa_data;
    if (wb_en) mem[wptr_b] <= wb_data;
  end

  assign rd0 = mem[rptr];
  assign rd1 = mem[rptr_b];

endmodule

// File: rtl/instr_queue.sv
// Dual-issue instruction queue between 2-wide fetch and decode, with
// bubble filtering, back-pressure and end-of-program drain tracking.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int XLEN  = instr_queue_pkg::XLEN,
  parameter int DEPTH = instr_queue_pkg::DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] fetch_instr1,
  input  logic [XLEN-1:0] fetch_instr2,
  input  logic            fetch_finish,
  output logic            fetch_stall,
  output logic [XLEN-1:0] dec_instr0,
  output logic            dec_valid0,
  output logic [XLEN-1:0] dec_instr1,
  output logic            dec_valid1,
  input  logic            dec_ready0,
  input  logic            dec_ready1,
  output logic [CW-1:0]   count,
  output logic            done
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  iq_state_t       state, state_next;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count_next;
  logic            nz1, nz2;
  logic            push_en;
  logic            wa_en, wb_en;
  logic [XLEN-1:0] wa_data;
  logic [XLEN-1:0] rd0, rd1;
  logic            fire0, fire1;
  logic [1:0]      push_n, pop_n;

  assign nz1 = (fetch_instr1 != XLEN'(BUBBLE));
  assign nz2 = (fetch_instr2 != XLEN'(BUBBLE));

  // A lone younger word still lands at wptr so the queue stays dense.
  assign push_en = (state == Q_RUN) && !fetch_stall && !flush;
  assign wa_en   = push_en && (nz1 || nz2);
  assign wa_data = nz1 ? fetch_instr1 : fetch_instr2;
  assign wb_en   = push_en && nz1 && nz2;
  assign push_n  = {1'b0, wa_en} + {1'b0, wb_en};

  assign fire0 = dec_valid0 && dec_ready0 && !flush;
  assign fire1 = fire0 && dec_valid1 && dec_ready1;
  assign pop_n = {1'b0, fire0} + {1'b0, fire1};

  assign count_next = count + CW'(push_n) - CW'(pop_n);

  instr_queue_mem #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .wptr   (wptr),
    .wa_en  (wa_en),
    .wa_data(wa_data),
    .wb_en  (wb_en),
    .wb_data(fetch_instr2),
    .rptr   (rptr),
    .rd0    (rd0),
    .rd1    (rd1)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= Q_RUN;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      state <= Q_RUN;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      wptr  <= wptr + PW'(push_n);
      rptr  <= rptr + PW'(pop_n);
      count <= count_next;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      Q_RUN:   if (fetch_finish) state_next = Q_DRAIN;
      Q_DRAIN: if (count_next == '0) state_next = Q_DONE;
      Q_DONE:  state_next = Q_DONE;
      default: state_next = Q_RUN;
    endcase
  end

  // Stall looks at the pre-pop count, so a same-cycle pop can never be relied on for space.
  always_comb begin
    fetch_stall = ((DEPTH_C - count) < CW'(2)) || (state != Q_RUN);
    done        = (state == Q_DONE);
    dec_valid0  = (state != Q_DONE) && (count >= CW'(1));
    dec_valid1  = (state != Q_DONE) && (count >= CW'(2));
  end

  assign dec_instr0 = dec_valid0 ? rd0 : '0;
  assign dec_instr1 = dec_valid1 ? rd1 : '0;

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue with hand-computed expectations.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] fetch_instr1, fetch_instr2;
  logic        fetch_finish;
  logic        fetch_stall;
  logic [31:0] dec_instr0, dec_instr1;
  logic        dec_valid0, dec_valid1;
  logic        dec_ready0, dec_ready1;
  logic [3:0]  count;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  instr_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fetch_instr1(fetch_instr1),
    .fetch_instr2(fetch_instr2),
    .fetch_finish(fetch_finish),
    .fetch_stall (fetch_stall),
    .dec_instr0  (dec_instr0),
    .dec_valid0  (dec_valid0),
    .dec_instr1  (dec_instr1),
    .dec_valid1  (dec_valid1),
    .dec_ready0  (dec_ready0),
    .dec_ready1  (dec_ready1),
    .count       (count),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i1, input logic [31:0] i2,
                       input logic r0, input logic r1);
    fetch_instr1 = i1;
    fetch_instr2 = i2;
    dec_ready0   = r0;
    dec_ready1   = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int cnt, input logic v0,
                             input logic v1, input logic stall, input logic dn);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".valid0"}, 32'(dec_valid0), 32'(v0));
    check({tag, ".valid1"}, 32'(dec_valid1), 32'(v1));
    check({tag, ".stall"}, 32'(fetch_stall), 32'(stall));
    check({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    fetch_finish = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    check_state("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.instr0", dec_instr0, 32'h0);
    check("reset.instr1", dec_instr1, 32'h0);
    rst_n = 1'b1;
    step();

    // 1: pair push, then dual pop
    drive(32'h00500093, 32'h00A00113, 1'b1, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b1, 1'b1);
    check_state("t1.push", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1.instr0", dec_instr0, 32'h00500093);
    check("t1.instr1", dec_instr1, 32'h00A00113);
    step();
    check_state("t1.pop", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: bubble in older slot, younger word enqueued alone
    drive(32'h0, 32'h00000033, 1'b0, 1'b0);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check_state("t2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2.instr0", dec_instr0, 32'h00000033);
    check("t2.instr1", dec_instr1, 32'h0);
    drive(32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("t2.pop.count", 32'(count), 32'd0);

    // 3: fill to 7, stall, ignored pair, then drain across the wrap
    drive(32'h11, 32'h0, 1'b0, 1'b0);
    step();
    drive(32'h21, 32'h22, 1'b0, 1'b0);
    step();
    drive(32'h31, 32'h32, 1'b0, 1'b0);
    step();
    drive(32'h41, 32'h42, 1'b0, 1'b0);
    step();
    check_state("t3.full", 7, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(32'h51, 32'h52, 1'b0, 1'b0);
    step();
    check("t3.ignored.count", 32'(count), 32'd7);
    check("t3.h0", dec_instr0, 32'h11);
    check("t3.h1", dec_instr1, 32'h21);
    drive(32'h0, 32'h0, 1'b1, 1'b1);
    step();
    check("t3.d1.count", 32'(count), 32'd5);
    check("t3.d1.h0", dec_instr0, 32'h22);
    check("t3.d1.h1", dec_instr1, 32'h31);
    step();
    check("t3.d2.count", 32'(count), 32'd3);
    check("t3.d2.h0", dec_instr0, 32'h32);
    check("t3.d2.h1", dec_instr1, 32'h41);
    step();
    check_state("t3.d3", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3.d3.h0", dec_instr0, 32'h42);
    step();
    check("t3.d4.count", 32'(count), 32'd0);

    // 4: ready1 without ready0 pops nothing
    drive(32'h61, 32'h62, 1'b0, 1'b1);
    step();
    drive(32'h63, 32'h0, 1'b0, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b1);
    step();
    check("t4.count", 32'(count), 32'd3);
    check("t4.h0", dec_instr0, 32'h61);

    // 5: finish at count 4, single-slot drain to done
    drive(32'h64, 32'h0, 1'b0, 1'b0);
    step();
    check("t5.count4", 32'(count), 32'd4);
    drive(32'h0, 32'h0, 1'b1, 1'b0);
    fetch_finish = 1'b1;
    step();
    fetch_finish = 1'b0;
    check_state("t5.c3", 3, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t5.c3.h0", dec_instr0, 32'h62);
    step();
    check("t5.c2", 32'(count), 32'd2);
    step();
    check("t5.c1", 32'(count), 32'd1);
    check("t5.c1.h0", dec_instr0, 32'h64);
    step();
    check_state("t5.done", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(32'h71, 32'h72, 1'b1, 1'b1);
    step();
    check_state("t5.held", 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 6: flush clears done, flush overrides push, then async reset mid-cycle
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_state("t6.flush", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(32'h81, 32'h82, 1'b0, 1'b0);
    step();
    check("t6.push.count", 32'(count), 32'd2);
    drive(32'h83, 32'h84, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_state("t6.flush2", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(32'h91, 32'h92, 1'b0, 1'b0);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("t6.refill.count", 32'(count), 32'd2);
    check("t6.refill.h0", dec_instr0, 32'h91);
    #3 rst_n = 1'b0;
    #1;
    check_state("t6.rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6.rst.instr0", dec_instr0, 32'h0);
    #2 rst_n = 1'b1;
    drive(32'ha1, 32'h0, 1'b0, 1'b0);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("t6.post.count", 32'(count), 32'd1);
    check("t6.post.h0", dec_instr0, 32'ha1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
